// File: rtl/alu_pkg.sv
// alu_pkg: opcode and sequencer state encodings
// shared by the multicycle ALU and the control unit.
package alu_pkg;

  localparam logic [4:0] OP_ADD  = 5'h01;
  localparam logic [4:0] OP_SUB  = 5'h02;
  localparam logic [4:0] OP_MUL  = 5'h03;
  localparam logic [4:0] OP_DIV  = 5'h04;
  localparam logic [4:0] OP_SHR  = 5'h05;
  localparam logic [4:0] OP_SHL  = 5'h06;
  localparam logic [4:0] OP_SHRA = 5'h07;
  localparam logic [4:0] OP_ROR  = 5'h08;
  localparam logic [4:0] OP_ROL  = 5'h09;
  localparam logic [4:0] OP_AND  = 5'h0A;
  localparam logic [4:0] OP_OR   = 5'h0B;
  localparam logic [4:0] OP_NEG  = 5'h0C;
  localparam logic [4:0] OP_XOR  = 5'h0D;
  localparam logic [4:0] OP_NOR  = 5'h0E;
  localparam logic [4:0] OP_NOT  = 5'h0F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: radix-2 signed multiply / restoring
// divide engine, one step per cycle on operand magnitudes.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               go,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] res,
  output logic               dz,
  output logic               fin,
  output logic               busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int W2  = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             div_q, div_d;
  logic             dz_q, dz_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH:0]   msum, trial;
  logic [W2-1:0]    mstep, dstep;
  logic             b_zero;

  assign b_zero = (b == '0);

  // State register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: divide by zero skips iteration
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (go) state_d = (is_div && b_zero) ? ST_FIX : ST_ITER;
      ST_ITER: if (cnt_q == '0) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // One shift-add or restoring-subtract step
  always_comb begin
    abs_a = a[WIDTH-1] ? -a : a;
    abs_b = b[WIDTH-1] ? -b : b;
    msum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, m_q};
    mstep = acc_q[0] ? {msum, acc_q[WIDTH-1:1]}
                     : {1'b0, acc_q[W2-1:1]};
    trial = acc_q[W2-1:WIDTH-1] - {1'b0, m_q};
    dstep = trial[WIDTH]
          ? {acc_q[W2-2:0], 1'b0}
          : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  end

  // Operand load on issue, step while iterating
  always_comb begin
    cnt_d = cnt_q;
    m_d   = m_q;
    acc_d = acc_q;
    div_d = div_q;
    dz_d  = dz_q;
    sa_d  = sa_q;
    sb_d  = sb_q;
    if (state_q == ST_IDLE && go) begin
      div_d = is_div;
      dz_d  = is_div && b_zero;
      sa_d  = a[WIDTH-1];
      sb_d  = b[WIDTH-1];
      cnt_d = SHW'(WIDTH - 1);
      if (is_div && b_zero) begin
        acc_d = {a, {WIDTH{1'b1}}};
      end else if (is_div) begin
        m_d   = abs_b;
        acc_d = {{WIDTH{1'b0}}, abs_a};
      end else begin
        m_d   = abs_a;
        acc_d = {{WIDTH{1'b0}}, abs_b};
      end
    end else if (state_q == ST_ITER) begin
      acc_d = div_q ? dstep : mstep;
      cnt_d = cnt_q - SHW'(1);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
      m_q   <= '0;
      acc_q <= '0;
      div_q <= 1'b0;
      dz_q  <= 1'b0;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      m_q   <= m_d;
      acc_q <= acc_d;
      div_q <= div_d;
      dz_q  <= dz_d;
      sa_q  <= sa_d;
      sb_q  <= sb_d;
    end
  end

  // Outputs: sign correction of magnitude result
  always_comb begin
    q_fix = (sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    r_fix = sa_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    if (dz_q)       res = acc_q;
    else if (div_q) res = {r_fix, q_fix};
    else            res = (sa_q ^ sb_q) ? -acc_q : acc_q;
    dz   = dz_q;
    fin  = (state_q == ST_FIX);
    busy = (state_q != ST_IDLE);
  end

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: single-cycle ALU ops plus an iterative
// mul/div engine behind a start/busy/done handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [4:0]         opcode,
  input  logic [WIDTH-1:0]   Y,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] C,
  output logic               busy,
  output logic               done,
  output logic               cout,
  output logic               ovf,
  output logic               zero,
  output logic               dz
);

  localparam int SHW = $clog2(WIDTH);

  logic               accept, is_md, go;
  logic               is_sub, sc_valid, sc_cout, sc_ovf;
  logic [SHW-1:0]     amt, namt;
  logic [WIDTH-1:0]   bx, sc_res;
  logic [WIDTH:0]     addr;
  logic [2*WIDTH-1:0] md_res;
  logic               md_dz, md_fin;

  logic [2*WIDTH-1:0] c_q, c_d;
  logic done_q, done_d, cout_q, cout_d;
  logic ovf_q, ovf_d, zero_q, zero_d, dz_q, dz_d;

  // Issue decode: iterative ops go to the engine
  always_comb begin
    accept = start && !busy;
    is_md  = (opcode == OP_MUL) || (opcode == OP_DIV);
    go     = accept && is_md;
  end

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .clr    (clr),
    .go     (go),
    .is_div (opcode == OP_DIV),
    .a      (Y),
    .b      (B),
    .res    (md_res),
    .dz     (md_dz),
    .fin    (md_fin),
    .busy   (busy)
  );

  // Single-cycle result and add/sub flags
  always_comb begin
    is_sub   = (opcode == OP_SUB);
    bx       = is_sub ? ~B : B;
    addr     = {1'b0, Y} + {1'b0, bx} + {{WIDTH{1'b0}}, is_sub};
    amt      = B[SHW-1:0];
    namt     = -amt;
    sc_res   = '0;
    sc_cout  = 1'b0;
    sc_ovf   = 1'b0;
    sc_valid = 1'b1;
    unique case (opcode)
      OP_ADD, OP_SUB: begin
        sc_res  = addr[WIDTH-1:0];
        sc_cout = addr[WIDTH];
        sc_ovf  = (Y[WIDTH-1] == bx[WIDTH-1]) &&
                  (addr[WIDTH-1] != Y[WIDTH-1]);
      end
      OP_SHR:  sc_res = Y >> amt;
      OP_SHL:  sc_res = Y << amt;
      OP_SHRA: sc_res = $signed(Y) >>> amt;
      OP_ROR:  sc_res = (Y >> amt) | (Y << namt);
      OP_ROL:  sc_res = (Y << amt) | (Y >> namt);
      OP_AND:  sc_res = Y & B;
      OP_OR:   sc_res = Y | B;
      OP_NEG:  sc_res = -Y;
      OP_XOR:  sc_res = Y ^ B;
      OP_NOR:  sc_res = ~(Y | B);
      OP_NOT:  sc_res = ~Y;
      default: sc_valid = 1'b0;
    endcase
  end

  // Result/flag capture from either path
  always_comb begin
    c_d    = c_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    dz_d   = dz_q;
    done_d = 1'b0;
    if (accept && !is_md) begin
      c_d    = {{WIDTH{1'b0}}, sc_res};
      cout_d = sc_cout;
      ovf_d  = sc_ovf;
      zero_d = sc_valid && (sc_res == '0);
      dz_d   = 1'b0;
      done_d = 1'b1;
    end else if (md_fin) begin
      c_d    = md_res;
      cout_d = 1'b0;
      ovf_d  = 1'b0;
      zero_d = (md_res[WIDTH-1:0] == '0);
      dz_d   = md_dz;
      done_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      c_q    <= '0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      c_q    <= c_d;
      done_q <= done_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      dz_q   <= dz_d;
    end
  end

  assign C    = c_q;
  assign done = done_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign dz   = dz_q;

endmodule
